// File: rtl/video_sync.sv
// Raster timing generator with a 4-clk pixel cadence and a small
// register port exposing position, frame count and vblank interrupt.
module video_sync #(
    parameter int H_DISPLAY = 160,
    parameter int H_FRONT   = 8,
    parameter int H_SYNC    = 16,
    parameter int H_BACK    = 16,
    parameter int V_DISPLAY = 96,
    parameter int V_FRONT   = 4,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic [7:0] hpos,
    output logic [6:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       pix_en,
    output logic       irq
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [7:0] H_LAST = 8'(H_TOTAL - 1);
    localparam logic [8:0] H_VIS  = 9'(H_DISPLAY);
    localparam logic [8:0] HS_BEG = 9'(H_DISPLAY + H_FRONT);
    localparam logic [8:0] HS_END = 9'(H_DISPLAY + H_FRONT + H_SYNC);

    localparam logic [6:0] V_LAST = 7'(V_TOTAL - 1);
    localparam logic [6:0] V_PRE  = 7'(V_DISPLAY - 1);
    localparam logic [6:0] V_BLK  = 7'(V_DISPLAY);
    localparam logic [7:0] V_VIS  = 8'(V_DISPLAY);
    localparam logic [7:0] VS_BEG = 8'(V_DISPLAY + V_FRONT);
    localparam logic [7:0] VS_END = 8'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [1:0] phase;
    logic [1:0] phase_next;
    logic [7:0] frame_cnt;
    logic [7:0] frame_next;
    logic       irq_pending;
    logic       irq_enable;
    logic       pend_next;
    logic       en_next;

    logic       step;
    logic       line_end;
    logic       vbl_start;
    logic       reg_wr;
    logic       rd_en;
    logic       vblank;
    logic [7:0] h_next;
    logic [6:0] v_next;
    logic [7:0] rd_data;
    logic       hs_next;
    logic       vs_next;
    logic       de_next;

    always_comb begin
        phase_next = phase + 2'd1;
        step       = (phase == 2'd3);
        line_end   = step && (hpos == H_LAST);
        h_next     = hpos;
        v_next     = vpos;
        if (step) begin
            h_next = line_end ? 8'd0 : hpos + 8'd1;
        end
        if (line_end) begin
            v_next = (vpos == V_LAST) ? 7'd0 : vpos + 7'd1;
        end
    end

    // Entering the first blanked line marks a new frame.
    assign vbl_start = line_end && (vpos == V_PRE) && (v_next == V_BLK);

    assign hs_next = ({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END);
    assign vs_next = ({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END);
    assign de_next = ({1'b0, h_next} < H_VIS) && ({1'b0, v_next} < V_VIS);

    assign reg_wr = cs && rw && (addr == 2'd3);
    assign rd_en  = cs && !rw;
    assign vblank = (vpos >= V_BLK);

    always_comb begin
        frame_next = frame_cnt + {7'd0, vbl_start};
        en_next    = reg_wr ? di[1] : irq_enable;
        pend_next  = irq_pending;
        if (reg_wr && di[0]) begin
            pend_next = 1'b0;
        end
        // A set landing on the same clk as a clear must not be lost.
        if (vbl_start) begin
            pend_next = 1'b1;
        end
    end

    always_comb begin
        rd_data = 8'd0;
        unique case (addr)
            2'd0: rd_data = hpos;
            2'd1: rd_data = {1'b0, vpos};
            2'd2: rd_data = frame_cnt;
            2'd3: rd_data = {5'd0, vblank, irq_enable, irq_pending};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= 2'd0;
            hpos        <= 8'd0;
            vpos        <= 7'd0;
            frame_cnt   <= 8'd0;
            irq_pending <= 1'b0;
            irq_enable  <= 1'b0;
            dout        <= 8'd0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            display_on  <= 1'b1;
            pix_en      <= 1'b0;
            irq         <= 1'b0;
        end else begin
            phase       <= phase_next;
            hpos        <= h_next;
            vpos        <= v_next;
            frame_cnt   <= frame_next;
            irq_pending <= pend_next;
            irq_enable  <= en_next;
            if (rd_en) begin
                dout <= rd_data;
            end
            hsync       <= hs_next;
            vsync       <= vs_next;
            display_on  <= de_next;
            pix_en      <= (phase_next == 2'd3);
            irq         <= pend_next && en_next;
        end
    end

endmodule

// File: tb/tb_video_sync.sv
// Directed bench for video_sync on a shrunken raster, checked every cycle
// against a position-from-time model plus literal spot values.
module tb_video_sync;

    localparam int HD = 4;
    localparam int HF = 1;
    localparam int HS = 2;
    localparam int HB = 1;
    localparam int VD = 2;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FR = HT * VT * 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0;
    logic       rw = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] di = 8'd0;
    logic [7:0] dout;
    logic [7:0] hpos;
    logic [6:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       pix_en;
    logic       irq;

    video_sync #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr),
        .di(di), .dout(dout), .hpos(hpos), .vpos(vpos),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .pix_en(pix_en), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: position is pure arithmetic on clks since reset.
    int         t = 0;
    logic [7:0] m_fc = 8'd0;
    logic [7:0] m_dout = 8'd0;
    logic       m_pend = 1'b0;
    logic       m_en = 1'b0;
    logic       m_set;
    bit         chk_on = 1'b0;

    function automatic int hp_of(int tt);
        return (tt / 4) % HT;
    endfunction

    function automatic int vp_of(int tt);
        return (tt / 4 / HT) % VT;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)",
                     name, act, exp, t);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            t      = 0;
            m_fc   = 8'd0;
            m_pend = 1'b0;
            m_en   = 1'b0;
            m_dout = 8'd0;
            chk_on = 1'b1;
        end else begin
            if (cs && !rw) begin
                case (addr)
                    2'd0: m_dout = 8'(hp_of(t));
                    2'd1: m_dout = 8'(vp_of(t));
                    2'd2: m_dout = m_fc;
                    default: m_dout = {5'd0, vp_of(t) >= VD, m_en, m_pend};
                endcase
            end
            m_set = (vp_of(t) == VD - 1) && (vp_of(t + 1) == VD);
            t = t + 1;
            if (m_set) m_fc = m_fc + 8'd1;
            if (cs && rw && addr == 2'd3) begin
                m_en = di[1];
                if (di[0]) m_pend = 1'b0;
            end
            if (m_set) m_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("hpos", int'(hpos), hp_of(t));
            chk("vpos", int'(vpos), vp_of(t));
            chk("hsync", int'(hsync),
                int'(hp_of(t) >= HD + HF && hp_of(t) < HD + HF + HS));
            chk("vsync", int'(vsync),
                int'(vp_of(t) >= VD + VF && vp_of(t) < VD + VF + VS));
            chk("display_on", int'(display_on),
                int'(hp_of(t) < HD && vp_of(t) < VD));
            chk("pix_en", int'(pix_en), int'(t % 4 == 3));
            chk("irq", int'(irq), int'(m_pend && m_en));
            chk("dout", int'(dout), int'(m_dout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b1; addr = a; di = d;
        tick();
        cs = 1'b0; rw = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        cs = 1'b1; rw = 1'b0; addr = a;
        tick();
        cs = 1'b0;
    endtask

    task automatic first_pix(output int k);
        k = 0;
        while (!pix_en && k < 16) begin
            tick();
            k++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n;
    int n_hs;
    int n_vs;
    int n_de;
    int n_wrap;
    int h_max;
    int guard;
    logic [6:0] v_prev;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_display_on", int'(display_on), 1);
        chk("reset_hpos", int'(hpos), 0);

        first_pix(n);
        chk("first_pix_en_cycle", n, 3);
        n = 0;
        repeat (40) begin
            tick();
            if (pix_en) n++;
        end
        chk("pix_en_per_40", n, 10);

        wr(2'd3, 8'h02);
        guard = 0;
        while (vp_of(t) != VD && guard < 400) begin
            tick();
            guard++;
        end
        chk("wait_vblank", int'(guard < 400), 1);
        chk("irq_at_vblank", int'(irq), 1);
        rd(2'd2);
        chk("frame_cnt_1", int'(dout), 1);
        rd(2'd3);
        chk("status_07", int'(dout), 8'h07);
        wr(2'd3, 8'h03);
        chk("irq_cleared", int'(irq), 0);

        guard = 0;
        while (!(t % 4 == 3 && hp_of(t) == HT - 1 && vp_of(t) == VD - 1)
               && guard < 400) begin
            tick();
            guard++;
        end
        chk("wait_set_cycle", int'(guard < 400), 1);
        wr(2'd3, 8'h03);
        chk("set_beats_clear", int'(irq), 1);
        rd(2'd3);
        chk("status_after_race", int'(dout), 8'h07);

        while (t % FR != 0) tick();
        n_hs = 0; n_vs = 0; n_de = 0; n_wrap = 0; h_max = 0;
        v_prev = vpos;
        repeat (FR) begin
            tick();
            if (hsync) n_hs++;
            if (vsync) n_vs++;
            if (display_on) n_de++;
            if (int'(hpos) > h_max) h_max = int'(hpos);
            if (vpos == 7'd0 && v_prev == 7'(VT - 1)) n_wrap++;
            v_prev = vpos;
        end
        chk("hsync_clks_frame", n_hs, 40);
        chk("vsync_clks_frame", n_vs, 32);
        chk("display_clks_frame", n_de, 32);
        chk("vpos_wraps", n_wrap, 1);
        chk("hpos_max", h_max, 7);

        wr(2'd0, 8'hFF);
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'hFF);

        guard = 0;
        while (!(hp_of(t) == 6 && vp_of(t) == 1 && t % 4 == 0)
               && guard < 400) begin
            tick();
            guard++;
        end
        rd(2'd0);
        chk("read_hpos_6", int'(dout), 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_hpos", int'(hpos), 0);
        chk("midreset_vpos", int'(vpos), 0);
        chk("midreset_dout", int'(dout), 0);
        chk("midreset_irq", int'(irq), 0);
        first_pix(n);
        chk("first_pix_after_midreset", n, 3);

        while (t < 255 * FR) tick();
        rd(2'd2);
        chk("frame_cnt_255", int'(dout), 255);
        while (t < 256 * FR) tick();
        rd(2'd2);
        chk("frame_cnt_wrap", int'(dout), 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_sync.md
VIDEO_SYNC -- requirements
Module: video_sync

Parameters
REQ-001 SHALL provide H_DISPLAY, default 160, visible pixels per line.
REQ-002 SHALL provide H_FRONT, default 8, pixels between visible end and hsync start.
REQ-003 SHALL provide H_SYNC, default 16, hsync width in pixels.
REQ-004 SHALL provide H_BACK, default 16, pixels after hsync; H_TOTAL = sum = 200, and every H_TOTAL SHALL be <= 256.
REQ-005 SHALL provide V_DISPLAY, default 96, visible lines.
REQ-006 SHALL provide V_FRONT, default 4; V_SYNC, default 4; V_BACK, default 16; V_TOTAL = sum = 120, and every V_TOTAL SHALL be <= 128.

Interface
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 cs  in  1  register select.
REQ-010 rw  in  1  1 = write, 0 = read; qualified by cs.
REQ-011 addr  in  2  register index.
REQ-012 di  in  8  write data.
REQ-013 dout  out  8  registered read data.
REQ-014 hpos  out  8  horizontal pixel counter.
REQ-015 vpos  out  7  line counter.
REQ-016 hsync  out  1  active-high horizontal sync.
REQ-017 vsync  out  1  active-high vertical sync.
REQ-018 display_on  out  1  high while hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-019 pix_en  out  1  one-clk strobe marking each pixel step.
REQ-020 irq  out  1  level interrupt request, equal to irq_pending & irq_enable.

Function
REQ-021 A 2-bit phase counter SHALL increment every clk and wrap 3->0; pix_en SHALL be high exactly when phase==3 (1 of every 4 clks).
REQ-022 hpos SHALL advance only on clks where pix_en=1, so it holds stable for 4 clks, aligned to a downstream 4-phase pixel pipeline.
REQ-023 When pix_en=1 and hpos==H_TOTAL-1: hpos->0, and vpos SHALL advance (V_TOTAL-1 -> 0).
REQ-024 All outputs SHALL be registers, derived from the next-state counters so they change on the same clk edge as hpos/vpos; no combinational output paths.
REQ-025 hsync SHALL be 1 for H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (168..183 at defaults).
REQ-026 vsync SHALL be 1 for V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (100..103 at defaults).
REQ-027 frame_cnt (8-bit) SHALL increment, wrapping 255->0, on the pixel step where vpos changes from V_DISPLAY-1 to V_DISPLAY (start of vblank).
REQ-028 On that same step, irq_pending SHALL be set.
REQ-029 Read map (cs=1, rw=0; dout updated on the next edge, else holds): 0 hpos; 1 {1'b0,vpos}; 2 frame_cnt; 3 {5'b0, vblank, irq_enable, irq_pending}; vblank = (vpos >= V_DISPLAY).
REQ-030 Write addr 3 (cs=1, rw=1): irq_enable <= di[1]; di[0]=1 SHALL clear irq_pending.
REQ-031 Writes to addr 0-2 SHALL be ignored.
REQ-032 If a clear of irq_pending and its set occur in the same clk, set SHALL win.

Reset
REQ-033 On reset, SHALL clear phase, hpos, vpos, frame_cnt, irq_pending, irq_enable, and dout to 0.
REQ-034 On reset, SHALL drive hsync=0, vsync=0, pix_en=0, irq=0, and display_on=1 (consistent with position 0,0).
REQ-035 Reset asserted mid-line or mid-frame SHALL take effect at the next edge regardless of phase.
REQ-036 After reset deasserts, the first pix_en SHALL occur on the 4th clk.

Verification
REQ-037 Release reset, run 800 clks -> pix_en every 4th clk; hpos 0..199 then back to 0; vpos increments to 1 exactly once.
REQ-038 Run a full frame (96000 clks) -> hsync high for exactly 64 clks per line, starting when hpos=168; vsync high for lines 100-103; display_on low when hpos>=160 or vpos>=96; vpos wraps 119->0.
REQ-039 Write addr3 di=0x02, run to vpos=96 -> irq=1 and frame_cnt=1; read addr3 -> 0x07; write di=0x03 -> irq=0 next clk.
REQ-040 Issue an irq_pending clear on the exact set cycle -> irq_pending stays 1.
REQ-041 Assert reset for 1 clk at hpos=150, vpos=50 -> all counters 0 next clk; dout=0; first pix_en 4 clks after reset release.
REQ-042 Write addr0 di=0xFF -> hpos unaffected; run 256 frames -> frame_cnt wraps to 0.
